// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - requester-side bundle for the bit-serial adder sequencer
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - WIDTH-bit add with carry-in over one shared 1-bit full-adder, LSB first
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_ctrl_if.slave req,
  output logic               fa_a,
  output logic               fa_b,
  output logic               fa_cin,
  input  logic               fa_sum,
  input  logic               fa_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q, cout_q;
  logic [CW-1:0]    count_q;
  logic             busy_c, done_c;
  logic [WIDTH-1:0] s_next;

  assign s_next = {fa_sum, s_sh[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    fa_a    = 1'b0;
    fa_b    = 1'b0;
    fa_cin  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req.start) state_d = RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        fa_a   = a_sh[0];
        fa_b   = b_sh[0];
        fa_cin = carry_q;
        if (count_q == LAST_BIT) state_d = DONE;
      end
      DONE: begin
        busy_c  = 1'b1;
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result registers only move on the final RUN edge so the requester sees a stable value otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req.start) begin
            a_sh    <= req.a;
            b_sh    <= req.b;
            carry_q <= req.cin;
            count_q <= '0;
            s_sh    <= '0;
          end
        end
        RUN: begin
          s_sh    <= s_next;
          carry_q <= fa_cout;
          a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
          count_q <= count_q + 1'b1;
          if (count_q == LAST_BIT) begin
            sum_q  <= s_next;
            cout_q <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign req.busy = busy_c;
  assign req.done = done_c;
  assign req.sum  = sum_q;
  assign req.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl with a behavioural full-adder
module tb_serial_adder_ctrl;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fa_a, fa_b, fa_cin, fa_sum, fa_cout;

  int checks = 0;
  int errors = 0;
  int dones  = 0;
  int pushes = 0;
  logic [WIDTH:0] exp_q[$];

  serial_adder_ctrl_if #(.WIDTH(WIDTH)) sif ();

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (sif.slave),
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_cin  (fa_cin),
    .fa_sum  (fa_sum),
    .fa_cout (fa_cout)
  );

  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic cin);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  endfunction

  always @(negedge clk) begin
    if (!rst && sif.done) begin
      dones++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(sif.done), 32'd0);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        check("sum", 32'(sif.sum), 32'(e[WIDTH-1:0]));
        check("cout", 32'(sif.cout), 32'(e[WIDTH]));
      end
    end
  end

  task automatic check_idle_fa(input string tag);
    check({tag, "_fa"}, {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
  endtask

  // One full operation: accept, walk every RUN cycle checking the adder feed, then DONE and back to IDLE.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                       input bit scramble);
    logic c;
    logic [WIDTH:0] r;
    r = model(a, b, cin);
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = a;
    sif.b     = b;
    sif.cin   = cin;
    exp_q.push_back(r);
    pushes++;
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0;
    if (scramble) begin
      sif.a   = '0;
      sif.b   = '0;
      sif.cin = 1'b0;
    end
    c = cin;
    for (int i = 0; i < WIDTH; i++) begin
      check("run_busy", 32'(sif.busy), 32'd1);
      check("run_done", 32'(sif.done), 32'd0);
      check("fa_a", 32'(fa_a), 32'(a[i]));
      check("fa_b", 32'(fa_b), 32'(b[i]));
      check("fa_cin", 32'(fa_cin), 32'(c));
      c = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      @(negedge clk);
    end
    check("done_pulse", 32'(sif.done), 32'd1);
    check("done_busy", 32'(sif.busy), 32'd1);
    check_idle_fa("done");
    @(negedge clk);
    check("post_done", 32'(sif.done), 32'd0);
    check("post_busy", 32'(sif.busy), 32'd0);
    check("post_sum", 32'(sif.sum), 32'(r[WIDTH-1:0]));
    check("post_cout", 32'(sif.cout), 32'(r[WIDTH]));
    check_idle_fa("idle");
  endtask

  initial begin
    sif.start = 1'b0;
    sif.a     = '0;
    sif.b     = '0;
    sif.cin   = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(sif.busy), 32'd0);
    check("rst_done", 32'(sif.done), 32'd0);
    check("rst_sum", 32'(sif.sum), 32'd0);
    check("rst_cout", 32'(sif.cout), 32'd0);
    check_idle_fa("rst");
    rst = 1'b0;

    do_op(8'h3C, 8'h5A, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    do_op(8'h80, 8'h80, 1'b0, 1'b1);

    // start held high: accepts at E0, E10, E20; start during RUN/DONE must not restart
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = 8'h01;
    sif.b     = 8'h01;
    sif.cin   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(model(8'h01, 8'h01, 1'b0));
      pushes++;
    end
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("held_done", 32'(sif.done), 32'((k % 10) == 8));
      check("held_busy", 32'(sif.busy), 32'((k % 10) != 9));
    end
    sif.start = 1'b0;
    @(negedge clk);
    check("held_stop", 32'(sif.busy), 32'd0);

    // reset while bit 4 is on the adder
    sif.start = 1'b1;
    sif.a     = 8'h55;
    sif.b     = 8'h0F;
    sif.cin   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_fa_a", 32'(fa_a), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(sif.busy), 32'd0);
    check("mid_rst_done", 32'(sif.done), 32'd0);
    check("mid_rst_sum", 32'(sif.sum), 32'd0);
    check("mid_rst_cout", 32'(sif.cout), 32'd0);
    check_idle_fa("mid_rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_done_after_rst", 32'(sif.busy), 32'd0);

    do_op(8'h12, 8'h34, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
    end

    repeat (2) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(dones), 32'(pushes));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial sequencer that time-shares a single 1-bit full-adder cell to perform a WIDTH-bit addition with carry-in. It sits between a requesting unit and one combinational full-adder instance, trading WIDTH cycles of latency for one adder cell. It loads operands on a start pulse, feeds one bit pair per clock LSB-first, collects the sum bits and final carry, and reports completion with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand and sum width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- cin  in  1  carry-in, captured on accepted start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse, results valid
- sum  out  WIDTH  registered result, held until next completion
- cout  out  1  registered final carry, held until next completion
- fa_a  out  1  bit to shared full-adder A input
- fa_b  out  1  bit to shared full-adder B input
- fa_cin  out  1  carry to shared full-adder Cin input
- fa_sum  in  1  full-adder Sum return (combinational)
- fa_cout  in  1  full-adder Cout return (combinational)

## Operation
- Internal state: a_sh, b_sh, s_sh (WIDTH each), carry flop, bit counter (clog2(WIDTH) bits), FSM state.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at edge → a_sh←a, b_sh←b, carry←cin, count←0, s_sh←0, go RUN. start=0 → stay.
- RUN: fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry. At each edge: s_sh←{fa_sum, s_sh[WIDTH-1:1]}, carry←fa_cout, a_sh/b_sh shift right by 1 (zero fill), count←count+1. When count==WIDTH-1 at the edge: sum←{fa_sum, s_sh[WIDTH-1:1]}, cout←fa_cout, go DONE.
- DONE: done=1 for exactly this cycle; next edge → IDLE unconditionally.
- start while busy (RUN or DONE) is ignored, not queued.
- fa_a, fa_b, fa_cin driven 0 outside RUN.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- sum/cout change only on the RUN→DONE edge; stable at all other times.

## Timing
- Reset (async, any state): state=IDLE, busy=0, done=0, sum=0, cout=0, fa_*=0, all internal registers 0. Reset mid-RUN abandons the operation; sum/cout return to 0, no done pulse.
- Start accepted at edge E0; busy=1 from E0 onward.
- RUN occupies WIDTH cycles (edges E1..EWIDTH); bit i is presented during cycle after edge Ei.
- done=1 during cycle after edge EWIDTH (WIDTH+1 edges after acceptance inclusive of E0); busy falls at edge EWIDTH+1.
- Earliest next start: sampled at edge EWIDTH+1 is ignored (still DONE); first accepted at EWIDTH+2. Throughput: one operation per WIDTH+2 cycles.
- Release of rst is assumed synchronous to clk by the system; first start may be sampled at the first edge after release.

## Test plan
- a=0x3C, b=0x5A, cin=0, start pulse → done exactly 9 cycles after accept edge; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Hold start high continuously with a=0x01,b=0x01 → operations accepted every 10 cycles, each sum=0x02; start during RUN/DONE never restarts.
- Accept a=0x80,b=0x80, then change a/b inputs during RUN to 0x00 → result still sum=0x00, cout=1 (operands captured at accept).
- Assert rst at bit 4 of a run → immediate IDLE, busy=0, sum=0, cout=0, no done; next start a=0x12,b=0x34 → sum=0x46.
- Check fa_a/fa_b/fa_cin each RUN cycle against LSB-first operand bits and ripple carry; all 0 in IDLE/DONE.
